spi_frame_scheduler: RTL and testbench

- Sits between the two payload sources in m_top (32-bit integer channel and 64-bit float channel) and the byte-level SPI master engine.
- Arbitrates the two requesters round-robin and frames each grant as one SS_N-bracketed transfer: a header byte followed by the payload, MSB byte first.
- Captures the full-duplex reply bytes and presents them as a completed word.
- Enforces SS setup, SS hold and inter-frame gap timing, and applies a per-byte timeout.

---
 rtl/spi_pkg.sv | 41 ++++
 rtl/spi_rr_arbiter.sv | 33 +++
 rtl/spi_frame_scheduler.sv | 169 ++++++++++++++++
 tb/tb_spi_frame_scheduler.sv | 387 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared states, header bytes, frame lengths and kind encodings
package spi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_LOAD,
        ST_WAIT,
        ST_HOLD,
        ST_GAP
    } state_t;

    localparam logic [7:0] HDR_INT  = 8'hA1;
    localparam logic [7:0] HDR_FLT  = 8'hA2;
    localparam logic [3:0] LEN_INT  = 4'd4;
    localparam logic [3:0] LEN_FLT  = 4'd8;
    localparam logic       KIND_INT = 1'b0;
    localparam logic       KIND_FLT = 1'b1;

    // Byte number cnt of a frame: header at 0, then payload bytes MSB first.
    function automatic logic [7:0] frame_byte(
        input logic [7:0]  hdr,
        input logic [63:0] payload,
        input logic [3:0]  last,
        input logic [3:0]  cnt
    );
        logic [7:0] b;
        logic [3:0] idx;
        b   = hdr;
        idx = last - cnt;
        if (cnt != 4'd0) begin
            for (int i = 0; i < 8; i++) begin
                if (idx == 4'(i)) begin
                    b = payload[i*8 +: 8];
                end
            end
        end
        return b;
    endfunction

endpackage

// File: rtl/spi_rr_arbiter.sv
// rtl/spi_rr_arbiter.sv - two-way round-robin arbiter, bit 0 = int, bit 1 = flt
module spi_rr_arbiter (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic [1:0] req,
    output logic [1:0] grant
);

    // Reset value makes the int channel win the first contested grant.
    logic last_flt;

    always_comb begin
        grant = 2'b00;
        if (enable) begin
            case (req)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = last_flt ? 2'b01 : 2'b10;
                default: grant = 2'b00;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_flt <= 1'b1;
        end else if (|grant) begin
            last_flt <= grant[1];
        end
    end

endmodule

// File: rtl/spi_frame_scheduler.sv
// rtl/spi_frame_scheduler.sv - arbitrates int/float payloads into SS-framed SPI byte transfers
module spi_frame_scheduler #(
    parameter int         SS_SETUP   = 4,
    parameter int         SS_HOLD    = 4,
    parameter int         GAP_CYCLES = 16,
    parameter int         TIMEOUT    = 4096,
    parameter logic [7:0] HDR_INT    = spi_pkg::HDR_INT,
    parameter logic [7:0] HDR_FLT    = spi_pkg::HDR_FLT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        int_req,
    input  logic [31:0] int_data,
    output logic        int_ack,
    input  logic        flt_req,
    input  logic [63:0] flt_data,
    output logic        flt_ack,
    output logic        spi_start,
    output logic [7:0]  spi_tx_byte,
    input  logic        spi_done,
    input  logic [7:0]  spi_rx_byte,
    output logic        ss_n,
    output logic        rx_valid,
    output logic        rx_kind,
    output logic [63:0] rx_data,
    output logic        busy,
    output logic        status
);

    import spi_pkg::*;

    localparam int M1      = (SS_SETUP > SS_HOLD) ? SS_SETUP : SS_HOLD;
    localparam int M2      = (GAP_CYCLES > TIMEOUT) ? GAP_CYCLES : TIMEOUT;
    localparam int CNT_MAX = (M1 > M2) ? M1 : M2;
    localparam int CW      = $clog2(CNT_MAX + 1);

    state_t        state;
    state_t        state_next;
    logic [CW-1:0] cnt;
    logic          cnt_run;
    logic          timeout_hit;
    logic [1:0]    grant;
    logic          kind;
    logic [3:0]    byte_cnt;
    logic [3:0]    last;
    logic [63:0]   payload;
    logic [63:0]   reply;
    logic [7:0]    hdr;

    spi_rr_arbiter u_arb (
        .clk    (clk),
        .reset  (reset),
        .enable (state == ST_IDLE),
        .req    ({flt_req, int_req}),
        .grant  (grant)
    );

    assign hdr       = (kind == KIND_FLT) ? HDR_FLT : HDR_INT;
    assign spi_start = (state == ST_LOAD);
    assign busy      = (state != ST_IDLE);

    always_comb begin
        state_next  = state;
        cnt_run     = 1'b0;
        timeout_hit = 1'b0;
        case (state)
            ST_IDLE: begin
                if (|grant) state_next = ST_SETUP;
            end
            ST_SETUP: begin
                cnt_run = 1'b1;
                if (int'(cnt) + 1 >= SS_SETUP) state_next = ST_LOAD;
            end
            ST_LOAD: begin
                state_next = ST_WAIT;
            end
            ST_WAIT: begin
                cnt_run = 1'b1;
                if (spi_done) begin
                    state_next = (byte_cnt == last) ? ST_HOLD : ST_LOAD;
                end else if (int'(cnt) + 1 >= TIMEOUT) begin
                    timeout_hit = 1'b1;
                    state_next  = ST_GAP;
                end
            end
            ST_HOLD: begin
                cnt_run = 1'b1;
                if (int'(cnt) + 1 >= SS_HOLD) state_next = ST_GAP;
            end
            ST_GAP: begin
                cnt_run = 1'b1;
                if (int'(cnt) + 1 >= GAP_CYCLES) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            int_ack     <= 1'b0;
            flt_ack     <= 1'b0;
            spi_tx_byte <= 8'h00;
            ss_n        <= 1'b1;
            rx_valid    <= 1'b0;
            rx_kind     <= KIND_INT;
            rx_data     <= 64'h0;
            status      <= 1'b0;
            kind        <= KIND_INT;
            byte_cnt    <= 4'd0;
            last        <= LEN_INT;
            payload     <= 64'h0;
            reply       <= 64'h0;
        end else begin
            state    <= state_next;
            // One counter serves every timed state; it restarts on each state change.
            cnt      <= (cnt_run && state_next == state) ? cnt + CW'(1) : '0;
            int_ack  <= 1'b0;
            flt_ack  <= 1'b0;
            rx_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (|grant) begin
                        int_ack  <= grant[0];
                        flt_ack  <= grant[1];
                        kind     <= grant[1] ? KIND_FLT : KIND_INT;
                        last     <= grant[1] ? LEN_FLT : LEN_INT;
                        payload  <= grant[1] ? flt_data : {32'h0, int_data};
                        byte_cnt <= 4'd0;
                        reply    <= 64'h0;
                        ss_n     <= 1'b0;
                    end
                end
                ST_SETUP: begin
                    if (state_next == ST_LOAD) begin
                        spi_tx_byte <= frame_byte(hdr, payload, last, 4'd0);
                    end
                end
                ST_WAIT: begin
                    if (spi_done) begin
                        // The byte clocked in alongside the header carries no reply data.
                        if (byte_cnt != 4'd0) begin
                            reply <= {reply[55:0], spi_rx_byte};
                        end
                        if (byte_cnt != last) begin
                            byte_cnt    <= byte_cnt + 4'd1;
                            spi_tx_byte <= frame_byte(hdr, payload, last, byte_cnt + 4'd1);
                        end
                    end else if (timeout_hit) begin
                        status <= 1'b1;
                        ss_n   <= 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (state_next == ST_GAP) begin
                        ss_n     <= 1'b1;
                        rx_valid <= 1'b1;
                        rx_kind  <= kind;
                        rx_data  <= reply;
                        status   <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_frame_scheduler.sv
// tb/tb_spi_frame_scheduler.sv - self-checking bench with echoing SPI slave and reply scoreboard
module tb_spi_frame_scheduler;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        int_req = 1'b0;
    logic [31:0] int_data = 32'h0;
    logic        int_ack;
    logic        flt_req = 1'b0;
    logic [63:0] flt_data = 64'h0;
    logic        flt_ack;
    logic        spi_start;
    logic [7:0]  spi_tx_byte;
    logic        spi_done;
    logic [7:0]  spi_rx_byte = 8'h00;
    logic        ss_n;
    logic        rx_valid;
    logic        rx_kind;
    logic [63:0] rx_data;
    logic        busy;
    logic        status;

    logic slave_done  = 1'b0;
    logic inject_done = 1'b0;
    assign spi_done = slave_done | inject_done;

    always #5 clk = ~clk;

    spi_frame_scheduler #(
        .SS_SETUP   (4),
        .SS_HOLD    (4),
        .GAP_CYCLES (16),
        .TIMEOUT    (4096),
        .HDR_INT    (8'hA1),
        .HDR_FLT    (8'hA2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .int_req     (int_req),
        .int_data    (int_data),
        .int_ack     (int_ack),
        .flt_req     (flt_req),
        .flt_data    (flt_data),
        .flt_ack     (flt_ack),
        .spi_start   (spi_start),
        .spi_tx_byte (spi_tx_byte),
        .spi_done    (spi_done),
        .spi_rx_byte (spi_rx_byte),
        .ss_n        (ss_n),
        .rx_valid    (rx_valid),
        .rx_kind     (rx_kind),
        .rx_data     (rx_data),
        .busy        (busy),
        .status      (status)
    );

    typedef struct {
        logic        kind;
        logic [63:0] data;
    } rx_t;

    typedef struct {
        logic        is_flt;
        logic [63:0] payload;
        logic [7:0]  hdr_reply;
        logic [63:0] echo;
        logic [63:0] exp_rx;
    } vec_t;

    rx_t        rx_sb[$];
    logic [7:0] tx_exp[$];
    logic [7:0] echo_q[$];

    int n_checks    = 0;
    int n_errors    = 0;
    int start_cnt   = 0;
    int mute_at     = 0;
    int cyc         = 0;
    int stamp       = 0;
    int rx_count    = 0;
    int int_ack_cnt = 0;
    int flt_ack_cnt = 0;
    int hi_run      = 0;
    bit seen_low    = 1'b0;
    logic prev_int_ack = 1'b0;
    logic prev_flt_ack = 1'b0;
    rx_t  mon_r;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic push_frame(input logic is_flt, input logic [63:0] payload,
                              input logic [7:0] hdr_reply, input logic [63:0] echo,
                              input logic [63:0] exp_rx);
        int n;
        n = is_flt ? 8 : 4;
        tx_exp.push_back(is_flt ? 8'hA2 : 8'hA1);
        for (int i = n - 1; i >= 0; i--) tx_exp.push_back(payload[i*8 +: 8]);
        echo_q.push_back(hdr_reply);
        for (int i = n - 1; i >= 0; i--) echo_q.push_back(echo[i*8 +: 8]);
        rx_sb.push_back('{is_flt, exp_rx});
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < 20000) begin
            @(negedge clk);
            n++;
        end
        check(name, busy, 0);
    endtask

    task automatic wait_any_ack(input string name);
        int n;
        n = 0;
        @(negedge clk);
        while (!(int_ack || flt_ack) && n < 20000) begin
            @(negedge clk);
            n++;
        end
        check(name, int_ack | flt_ack, 1);
    endtask

    // Grant from IDLE: ack must show one cycle after req, and for one cycle only.
    task automatic run_frame(input logic is_flt, input logic [63:0] payload, input string name);
        if (is_flt) begin
            flt_data = payload;
            flt_req  = 1'b1;
        end else begin
            int_data = payload[31:0];
            int_req  = 1'b1;
        end
        @(negedge clk);
        check({name, "_ack_latency"}, is_flt ? flt_ack : int_ack, 1);
        check({name, "_other_ack"}, is_flt ? int_ack : flt_ack, 0);
        int_req  = 1'b0;
        flt_req  = 1'b0;
        int_data = $urandom;
        flt_data = {$urandom, $urandom};
        @(negedge clk);
        check({name, "_ack_single"}, is_flt ? flt_ack : int_ack, 0);
        wait_idle({name, "_idle"});
        check({name, "_ss_n_idle"}, ss_n, 1);
    endtask

    always @(posedge clk) cyc++;

    // Slave: logs/checks each launched byte and answers two cycles later from echo_q.
    initial begin
        logic [7:0] e;
        @(negedge clk);
        forever begin
            if (spi_start) begin
                start_cnt++;
                check("ss_low_at_start", ss_n, 0);
                check("tx_expected", tx_exp.size() != 0, 1);
                if (tx_exp.size() != 0) begin
                    e = tx_exp.pop_front();
                    check("tx_byte", spi_tx_byte, e);
                end
                if (mute_at != 0 && start_cnt == mute_at) begin
                    stamp = cyc;
                    @(negedge clk);
                end else begin
                    repeat (2) @(negedge clk);
                    spi_rx_byte = (echo_q.size() != 0) ? echo_q.pop_front() : 8'h00;
                    slave_done  = 1'b1;
                    @(negedge clk);
                    slave_done  = 1'b0;
                end
            end else begin
                @(negedge clk);
            end
        end
    end

    always @(negedge clk) begin
        if (rx_valid) begin
            rx_count++;
            check("rx_expected", rx_sb.size() != 0, 1);
            if (rx_sb.size() != 0) begin
                mon_r = rx_sb.pop_front();
                check("rx_kind", rx_kind, mon_r.kind);
                check("rx_data", rx_data, mon_r.data);
            end
        end
        if (int_ack) begin
            int_ack_cnt++;
            check("int_ack_one_cycle", prev_int_ack, 0);
        end
        if (flt_ack) begin
            flt_ack_cnt++;
            check("flt_ack_one_cycle", prev_flt_ack, 0);
        end
        prev_int_ack = int_ack;
        prev_flt_ack = flt_ack;
        if (reset) begin
            seen_low = 1'b0;
            hi_run   = 0;
        end else if (ss_n) begin
            hi_run++;
        end else begin
            if (hi_run > 0 && seen_low) check("ss_gap_ge16", hi_run >= 16, 1);
            seen_low = 1'b1;
            hi_run   = 0;
        end
    end

    initial begin
        vec_t vecs[4];
        int   n;
        int   rxc;
        int   fac;

        vecs[0] = '{1'b0, 64'h0000_0000_1234_5678, 8'hC3, 64'h0000_0000_1122_3344, 64'h0000_0000_1122_3344};
        vecs[1] = '{1'b1, 64'h4009_21FB_5444_2D18, 8'hC3, 64'h0102_0304_0506_0708, 64'h0102_0304_0506_0708};
        vecs[2] = '{1'b0, 64'h0000_0000_FFFF_FFFF, 8'h00, 64'h0000_0000_FF80_017E, 64'h0000_0000_FF80_017E};
        vecs[3] = '{1'b1, 64'h0000_0000_0000_0000, 8'h5A, 64'h8877_6655_4433_2211, 64'h8877_6655_4433_2211};

        repeat (3) @(negedge clk);
        check("rst_int_ack", int_ack, 0);
        check("rst_flt_ack", flt_ack, 0);
        check("rst_spi_start", spi_start, 0);
        check("rst_spi_tx_byte", spi_tx_byte, 0);
        check("rst_ss_n", ss_n, 1);
        check("rst_rx_valid", rx_valid, 0);
        check("rst_rx_kind", rx_kind, 0);
        check("rst_rx_data", rx_data, 0);
        check("rst_busy", busy, 0);
        check("rst_status", status, 0);
        reset = 1'b0;
        @(negedge clk);

        for (int v = 0; v < 4; v++) begin
            push_frame(vecs[v].is_flt, vecs[v].payload, vecs[v].hdr_reply, vecs[v].echo, vecs[v].exp_rx);
            run_frame(vecs[v].is_flt, vecs[v].payload, "vec");
            check("vec_status", status, 0);
        end
        check("vec_rx_drained", rx_sb.size(), 0);

        // Round robin: both requesting from reset gives int, flt, int.
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        push_frame(1'b0, 64'h0000_0000_AABB_CCDD, 8'h00, 64'h0000_0000_0102_0304, 64'h0000_0000_0102_0304);
        push_frame(1'b1, 64'h1122_3344_5566_7788, 8'h00, 64'hF0E1_D2C3_B4A5_9687, 64'hF0E1_D2C3_B4A5_9687);
        push_frame(1'b0, 64'h0000_0000_0BAD_CAFE, 8'h00, 64'h0000_0000_5566_7788, 64'h0000_0000_5566_7788);
        int_data = 32'hAABB_CCDD;
        flt_data = 64'h1122_3344_5566_7788;
        int_req  = 1'b1;
        flt_req  = 1'b1;
        wait_any_ack("rr1_ack");
        check("rr1_int", int_ack, 1);
        check("rr1_not_flt", flt_ack, 0);
        int_req = 1'b0;
        @(negedge clk);
        int_data = 32'h0BAD_CAFE;
        int_req  = 1'b1;
        wait_any_ack("rr2_ack");
        check("rr2_flt", flt_ack, 1);
        check("rr2_not_int", int_ack, 0);
        flt_req = 1'b0;
        @(negedge clk);
        flt_req = 1'b1;
        wait_any_ack("rr3_ack");
        check("rr3_int", int_ack, 1);
        check("rr3_not_flt", flt_ack, 0);
        // flt drops its request while the frame runs and must never be granted.
        fac     = flt_ack_cnt;
        int_req = 1'b0;
        flt_req = 1'b0;
        wait_idle("rr3_idle");
        repeat (30) @(negedge clk);
        check("dropped_req_no_ack", flt_ack_cnt, fac);
        check("rr_rx_drained", rx_sb.size(), 0);

        // Timeout: the third byte never completes.
        start_cnt = 0;
        mute_at   = 3;
        tx_exp.push_back(8'hA1);
        tx_exp.push_back(8'hDE);
        tx_exp.push_back(8'hAD);
        echo_q.push_back(8'h00);
        echo_q.push_back(8'h77);
        int_data = 32'hDEAD_BEEF;
        int_req  = 1'b1;
        @(negedge clk);
        check("to_ack", int_ack, 1);
        int_req = 1'b0;
        rxc = rx_count;
        n   = 0;
        while (!ss_n && n < 6000) begin
            @(negedge clk);
            n++;
        end
        check("to_ss_n_high", ss_n, 1);
        check("to_len_in_range", (cyc - stamp >= 4096) && (cyc - stamp <= 4098), 1);
        check("to_status", status, 1);
        check("to_in_gap", busy, 1);
        wait_idle("to_idle");
        mute_at = 0;
        check("to_no_rx_valid", rx_count, rxc);
        check("to_status_sticky", status, 1);
        push_frame(1'b0, 64'h0000_0000_0BAD_F00D, 8'h33, 64'h0000_0000_C0DE_1234, 64'h0000_0000_C0DE_1234);
        run_frame(1'b0, 64'h0000_0000_0BAD_F00D, "after_to");
        check("to_status_cleared", status, 0);

        // Reset during byte 5 of a float frame.
        start_cnt = 0;
        tx_exp.push_back(8'hA2);
        tx_exp.push_back(8'h40);
        tx_exp.push_back(8'h09);
        tx_exp.push_back(8'h21);
        tx_exp.push_back(8'hFB);
        for (int i = 0; i < 5; i++) echo_q.push_back(8'h90 + 8'(i));
        flt_data = 64'h4009_21FB_5444_2D18;
        flt_req  = 1'b1;
        @(negedge clk);
        check("rst_mid_ack", flt_ack, 1);
        flt_req = 1'b0;
        n = 0;
        while (start_cnt < 5 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("rst_mid_reached_byte5", start_cnt >= 5, 1);
        reset = 1'b1;
        @(negedge clk);
        check("rst_mid_ss_n", ss_n, 1);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_rx_data", rx_data, 0);
        check("rst_mid_rx_valid", rx_valid, 0);
        reset = 1'b0;
        repeat (6) @(negedge clk);
        check("rst_mid_still_idle", busy, 0);
        check("rst_mid_tx_drained", tx_exp.size(), 0);
        check("rst_mid_echo_drained", echo_q.size(), 0);
        push_frame(1'b0, 64'h0000_0000_CAFE_BABE, 8'h10, 64'h0000_0000_2468_ACE0, 64'h0000_0000_2468_ACE0);
        run_frame(1'b0, 64'h0000_0000_CAFE_BABE, "after_rst");

        // Stray spi_done in IDLE and in GAP.
        rxc = rx_count;
        for (int i = 0; i < 4; i++) begin
            inject_done = 1'b1;
            @(negedge clk);
            check("idle_done_busy", busy, 0);
            check("idle_done_ss_n", ss_n, 1);
            inject_done = 1'b0;
            @(negedge clk);
        end
        check("idle_done_no_rx", rx_count, rxc);
        push_frame(1'b1, 64'h0123_4567_89AB_CDEF, 8'hEE, 64'h1357_9BDF_2468_ACE0, 64'h1357_9BDF_2468_ACE0);
        flt_data = 64'h0123_4567_89AB_CDEF;
        flt_req  = 1'b1;
        @(negedge clk);
        check("gap_ack", flt_ack, 1);
        flt_req = 1'b0;
        n = 0;
        while (rx_count == rxc && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check("gap_rx_seen", rx_count, rxc + 1);
        for (int i = 0; i < 3; i++) begin
            inject_done = 1'b1;
            @(negedge clk);
            check("gap_done_busy", busy, 1);
            check("gap_done_ss_n", ss_n, 1);
            check("gap_done_no_start", spi_start, 0);
        end
        inject_done = 1'b0;
        wait_idle("gap_idle");
        check("gap_done_no_extra_rx", rx_count, rxc + 1);
        check("final_rx_drained", rx_sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
